matmul_stream: RTL and testbench

MATMUL_STREAM -- requirements
Module: matmul_stream

---
 rtl/matmul_pkg.sv | 23 ++
 rtl/mac_lane.sv | 39 +++
 rtl/matmul_stream.sv | 203 ++++++++++++++++++++
 tb/tb_matmul_stream.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the streaming matrix-multiply block.
package matmul_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Accumulator width: full product plus growth for M terms, never narrower than 2*dw+1.
   function automatic int unsigned acc_width_f(input int unsigned dw, input int unsigned m);
      int unsigned w;
      w = 2 * dw + int'($clog2(m));
      if (w < 2 * dw + 1) w = 2 * dw + 1;
      return w;
   endfunction

   function automatic int unsigned idx_width_f(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane; clear has priority over enable.
module mac_lane #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ACC_WIDTH  = 35
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         enable,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [ACC_WIDTH-1:0]  acc,
   output logic signed [ACC_WIDTH-1:0]  acc_nxt_c
);

   localparam int unsigned PW = 2 * DATA_WIDTH;

   logic signed [PW-1:0]        prod_c;
   logic signed [ACC_WIDTH-1:0] acc_d, acc_q;

   always_comb begin
      prod_c = a * b;
      acc_d  = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (enable) begin
         acc_d = acc_q + {{(ACC_WIDTH-PW){prod_c[PW-1]}}, prod_c};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) acc_q <= '0;
      else        acc_q <= acc_d;
   end

   assign acc       = acc_q;
   assign acc_nxt_c = acc_d;

endmodule

// File: rtl/matmul_stream.sv
// Streaming N x M by M x Q matrix multiply, NUM_PE result columns per tile.
// Define MATMUL_STREAM_SAT_EN to clamp results to the signed 2*DATA_WIDTH range.
module matmul_stream import matmul_pkg::*; #(
   parameter  int unsigned DATA_WIDTH = 16,
   parameter  int unsigned N          = 4,
   parameter  int unsigned M          = 8,
   parameter  int unsigned Q          = 8,
   parameter  int unsigned NUM_PE     = 4,
   localparam int unsigned ACC_WIDTH  = acc_width_f(DATA_WIDTH, M),
   localparam int unsigned RW         = idx_width_f(N),
   localparam int unsigned CW         = idx_width_f(Q)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_a,
   input  logic [NUM_PE*DATA_WIDTH-1:0] in_b,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [ACC_WIDTH-1:0]  out_data,
   output logic [RW-1:0]                out_row,
   output logic [CW-1:0]                out_col
);

   localparam int unsigned NUM_TILES = (Q + NUM_PE - 1) / NUM_PE;
   localparam int unsigned TW        = idx_width_f(NUM_TILES);
   localparam int unsigned KW        = idx_width_f(M);
   localparam int unsigned PW        = idx_width_f(NUM_PE);

   state_e                      state_q, state_d;
   logic [RW-1:0]               r_q, r_d;
   logic [TW-1:0]               t_q, t_d;
   logic [KW-1:0]               k_q, k_d;
   logic [PW-1:0]               p_q, p_d;
   logic                        busy_q, busy_d, done_q, done_d;
   logic                        in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic signed [ACC_WIDTH-1:0] out_data_q, out_data_d;
   logic [RW-1:0]               out_row_q, out_row_d;
   logic [CW-1:0]               out_col_q, out_col_d;
   logic                        beat_c, out_hs_c, clear_c;
   logic                        last_k_c, last_lane_c, last_tile_c, last_row_c;
   logic [31:0]                 col_nxt_c;
   logic signed [ACC_WIDTH-1:0] acc_w     [NUM_PE];
   logic signed [ACC_WIDTH-1:0] acc_nxt_w [NUM_PE];

   function automatic logic signed [ACC_WIDTH-1:0] fmt_f(input logic signed [ACC_WIDTH-1:0] v);
`ifdef MATMUL_STREAM_SAT_EN
      logic signed [ACC_WIDTH-1:0] hi, lo;
      hi = ACC_WIDTH'({1'b0, {(2*DATA_WIDTH-1){1'b1}}});
      lo = ~hi;
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
`else
      return v;
`endif
   endfunction

   for (genvar p = 0; p < NUM_PE; p++) begin : g_lane
      mac_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .ACC_WIDTH  (ACC_WIDTH)
      ) u_mac (
         .clk       (clk),
         .reset     (reset),
         .clear     (clear_c),
         .enable    (beat_c),
         .a         (in_a),
         .b         (in_b[p*DATA_WIDTH +: DATA_WIDTH]),
         .acc       (acc_w[p]),
         .acc_nxt_c (acc_nxt_w[p])
      );
   end

   assign beat_c      = (state_q == ST_ACCUM) && in_valid && in_ready_q;
   assign out_hs_c    = out_valid_q && out_ready;
   assign last_k_c    = (k_q == KW'(M - 1));
   assign last_tile_c = (t_q == TW'(NUM_TILES - 1));
   assign last_row_c  = (r_q == RW'(N - 1));
   assign col_nxt_c   = 32'(t_q) * NUM_PE + 32'(p_q) + 32'd1;
   // Lanes past column Q-1 in the final tile are skipped.
   assign last_lane_c = (p_q == PW'(NUM_PE - 1)) || (col_nxt_c >= Q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_ACCUM;
         ST_ACCUM: if (beat_c && last_k_c) state_d = ST_DRAIN;
         ST_DRAIN: if (out_hs_c && last_lane_c)
                      state_d = (last_tile_c && last_row_c) ? ST_DONE : ST_ACCUM;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      r_d         = r_q;
      t_d         = t_q;
      k_d         = k_q;
      p_d         = p_q;
      clear_c     = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               r_d     = '0;
               t_d     = '0;
               k_d     = '0;
               p_d     = '0;
               clear_c = 1'b1;
            end
         end
         ST_ACCUM: begin
            if (beat_c) begin
               if (last_k_c) begin
                  // Lane 0 is presented straight from the final beat's sum.
                  k_d         = '0;
                  p_d         = '0;
                  out_valid_d = 1'b1;
                  out_data_d  = fmt_f(acc_nxt_w[0]);
                  out_row_d   = r_q;
                  out_col_d   = CW'(32'(t_q) * NUM_PE);
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (out_hs_c) begin
               if (last_lane_c) begin
                  out_valid_d = 1'b0;
                  if (state_d == ST_ACCUM) begin
                     clear_c = 1'b1;
                     if (last_tile_c) begin
                        t_d = '0;
                        r_d = r_q + 1'b1;
                     end else begin
                        t_d = t_q + 1'b1;
                     end
                  end
               end else begin
                  p_d        = p_q + 1'b1;
                  out_data_d = fmt_f(acc_w[p_q + 1'b1]);
                  out_col_d  = out_col_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_DONE);
      in_ready_d = (state_d == ST_ACCUM);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q         <= '0;
         t_q         <= '0;
         k_q         <= '0;
         p_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
      end else begin
         r_q         <= r_d;
         t_q         <= t_d;
         k_q         <= k_d;
         p_q         <= p_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_row   = out_row_q;
   assign out_col   = out_col_q;

endmodule

// File: tb/tb_matmul_stream.sv
// Directed bench for matmul_stream: 2x8 by 8x5 products on 4 lanes (two tiles, ragged last tile).
module tb_matmul_stream;

   localparam int DW    = 16;
   localparam int N     = 2;
   localparam int M     = 8;
   localparam int Q     = 5;
   localparam int NP    = 4;
   localparam int NT    = 2;
   localparam int ACC_W = 35;
   localparam int NOUT  = N * Q;

   logic                 clk = 1'b0;
   logic                 reset, start, in_valid, out_ready;
   logic                 busy, done, in_ready, out_valid;
   logic signed [DW-1:0] in_a;
   logic [NP*DW-1:0]     in_b;
   logic [ACC_W-1:0]     out_data;
   logic [0:0]           out_row;
   logic [2:0]           out_col;

   int     vec_cnt = 0;
   int     err_cnt = 0;
   int     a_m [N][M];
   int     b_m [M][Q];
   longint exp_v [NOUT];

   matmul_stream #(
      .DATA_WIDTH (DW),
      .N          (N),
      .M          (M),
      .Q          (Q),
      .NUM_PE     (NP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
      vec_cnt++;
      assert (obs === expv) else begin
         err_cnt++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic load_t1();
      for (int r = 0; r < N; r++) for (int k = 0; k < M; k++) a_m[r][k] = 0;
      a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
      for (int k = 2; k < M; k++) for (int c = 0; c < Q; c++) b_m[k][c] = 100;
      b_m[0][0] = 5; b_m[0][1] = 6; b_m[0][2] = 1;  b_m[0][3] = -2; b_m[0][4] = 3;
      b_m[1][0] = 7; b_m[1][1] = 8; b_m[1][2] = -1; b_m[1][3] = 4;  b_m[1][4] = 0;
      exp_v[0] = 19; exp_v[1] = 22; exp_v[2] = -1; exp_v[3] = 6;  exp_v[4] = 3;
      exp_v[5] = 43; exp_v[6] = 50; exp_v[7] = -1; exp_v[8] = 10; exp_v[9] = 9;
   endtask

   task automatic load_t3();
      for (int k = 0; k < M; k++) begin
         a_m[0][k] = 1;
         a_m[1][k] = 2;
         for (int c = 0; c < Q; c++) b_m[k][c] = k + c;
      end
      exp_v[0] = 28; exp_v[1] = 36; exp_v[2] = 44;  exp_v[3] = 52;  exp_v[4] = 60;
      exp_v[5] = 56; exp_v[6] = 72; exp_v[7] = 88;  exp_v[8] = 104; exp_v[9] = 120;
   endtask

   task automatic load_min();
      for (int k = 0; k < M; k++) begin
         a_m[0][k] = -32768;
         a_m[1][k] = -32768;
         for (int c = 0; c < Q; c++) b_m[k][c] = -32768;
      end
      for (int i = 0; i < NOUT; i++) begin
`ifdef MATMUL_STREAM_SAT_EN
         exp_v[i] = 64'sd2147483647;
`else
         exp_v[i] = 64'sd8589934592;
`endif
      end
   endtask

   // Runs one product cycle by cycle; all sampling and driving happens on the falling edge.
   task automatic run_product(input bit gaps, input bit stalls, input bit poke_start, input bit abort);
      int feed  = 0;
      int outi  = 0;
      int dones = 0;
      int cyc   = 0;
      bit held  = 1'b0;
      logic [ACC_W-1:0] hd;
      logic [0:0]       hr;
      logic [2:0]       hc;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (cyc < 3000) begin
         if (held) begin
            check("stall_valid", 64'(out_valid), 64'sd1);
            check("stall_data", 64'(out_data), 64'(hd));
            check("stall_col", 64'(out_col), 64'(hc));
            check("stall_row", 64'(out_row), 64'(hr));
         end
         if (done) dones++;
         if (dones > 0 && outi >= NOUT) break;
         if (abort && out_valid) begin
            in_valid = 1'b0;
            return;
         end
         if (feed < N * NT * M && (!gaps || $urandom_range(1, 0) == 1)) begin
            int r, t, k;
            r = feed / (NT * M);
            t = (feed / M) % NT;
            k = feed % M;
            in_valid = 1'b1;
            in_a = 16'(a_m[r][k]);
            for (int p = 0; p < NP; p++) begin
               int col;
               col = t * NP + p;
               in_b[p*DW +: DW] = (col < Q) ? 16'(b_m[k][col]) : 16'h5a5a;
            end
         end else begin
            in_valid = 1'b0;
         end
         out_ready = stalls ? 1'($urandom_range(1, 0)) : 1'b1;
         start = (poke_start && cyc == 6) ? 1'b1 : 1'b0;
         if (in_valid && in_ready) feed++;
         if (out_valid && out_ready) begin
            if (outi < NOUT) begin
               check("out_data", $signed(out_data), exp_v[outi]);
               check("out_row", 64'(out_row), 64'(outi / Q));
               check("out_col", 64'(out_col), 64'(outi % Q));
            end else begin
               check("extra_out", 64'(outi), 64'(NOUT - 1));
            end
            outi++;
         end
         held = out_valid && !out_ready;
         hd = out_data; hr = out_row; hc = out_col;
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      check("out_count", 64'(outi), 64'(NOUT));
      repeat (4) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("done_count", 64'(dones), 64'sd1);
      check("busy_idle", 64'(busy), 64'sd0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'sd0);
      check("rst_done", 64'(done), 64'sd0);
      check("rst_in_ready", 64'(in_ready), 64'sd0);
      check("rst_out_valid", 64'(out_valid), 64'sd0);
      check("rst_out_data", 64'(out_data), 64'sd0);
      check("rst_out_row", 64'(out_row), 64'sd0);
      check("rst_out_col", 64'(out_col), 64'sd0);
      reset = 1'b1;
      @(negedge clk);
      check("idle_in_ready", 64'(in_ready), 64'sd0);

      load_t1();
      run_product(1'b0, 1'b0, 1'b0, 1'b0);

      run_product(1'b1, 1'b1, 1'b0, 1'b0);

      load_t3();
      run_product(1'b0, 1'b1, 1'b1, 1'b0);

      load_min();
      run_product(1'b1, 1'b0, 1'b0, 1'b0);

      load_t3();
      run_product(1'b0, 1'b0, 1'b0, 1'b1);
      out_ready = 1'b0;
      reset = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'sd0);
      check("abort_out_valid", 64'(out_valid), 64'sd0);
      check("abort_in_ready", 64'(in_ready), 64'sd0);
      check("abort_out_data", 64'(out_data), 64'sd0);
      @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("post_abort_valid", 64'(out_valid), 64'sd0);
      check("post_abort_busy", 64'(busy), 64'sd0);
      run_product(1'b1, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
